// File: rtl/add_sub_if.sv
// Operand/result bundle for the registered sign-magnitude adder/subtractor.
// The master drives operands and the operation select; the slave returns the result.
interface add_sub_if;
  logic [2:0] num1;
  logic [2:0] num2;
  logic       selection;
  logic [4:0] result;
  logic       zeroflag;

  modport master (
    output num1,
    output num2,
    output selection,
    input  result,
    input  zeroflag
  );

  modport slave (
    input  num1,
    input  num2,
    input  selection,
    output result,
    output zeroflag
  );
endinterface

// File: rtl/add_sub.sv
// Registered 3-bit sign-magnitude add/subtract producing a 5-bit sign-magnitude result
// and a zero flag, both updated on every rising clock edge.
module add_sub (
  input  logic      clk,
  input  logic      rst_n,
  add_sub_if.slave  bus
);

  logic signed [4:0] a;
  logic signed [4:0] b;
  logic signed [4:0] s;
  logic        [3:0] mag;
  logic        [4:0] result_d;
  logic              zeroflag_d;
  logic        [4:0] result_q;
  logic              zeroflag_q;

  // -0 decodes to 0 naturally because negating zero yields zero.
  always_comb begin
    a = $signed({3'b000, bus.num1[1:0]});
    b = $signed({3'b000, bus.num2[1:0]});
    if (bus.num1[2]) a = 5'sd0 - a;
    if (bus.num2[2]) b = 5'sd0 - b;
  end

  always_comb begin
    s = bus.selection ? (a - b) : (a + b);
    // |S| <= 6 fits in 4 bits; a zero S has a clear sign bit so -0 never appears.
    mag        = s[4] ? (4'd0 - s[3:0]) : s[3:0];
    result_d   = {s[4], mag};
    zeroflag_d = (mag == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= 5'b00000;
      zeroflag_q <= 1'b1;
    end else begin
      result_q   <= result_d;
      zeroflag_q <= zeroflag_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zeroflag = zeroflag_q;

endmodule

// File: tb/tb_add_sub.sv
// Directed and exhaustive checks of the registered sign-magnitude adder/subtractor.
module tb_add_sub;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  add_sub_if bus ();

  add_sub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] exp_r, input logic exp_z);
    checks++;
    assert (bus.result === exp_r) else begin
      failures++;
      $error("FAIL %s result: got %b expected %b", tag, bus.result, exp_r);
    end
    checks++;
    assert (bus.zeroflag === exp_z) else begin
      failures++;
      $error("FAIL %s zeroflag: got %b expected %b", tag, bus.zeroflag, exp_z);
    end
  endtask

  // Drive operands away from the edge, then sample just after the capturing edge.
  task automatic apply(input logic [2:0] n1, input logic [2:0] n2, input logic sel);
    @(negedge clk);
    bus.num1      = n1;
    bus.num2      = n2;
    bus.selection = sel;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ref_result(input logic [2:0] n1, input logic [2:0] n2,
                                            input logic sel);
    int va;
    int vb;
    int sv;
    logic [3:0] m;
    va = n1[2] ? -int'(n1[1:0]) : int'(n1[1:0]);
    vb = n2[2] ? -int'(n2[1:0]) : int'(n2[1:0]);
    sv = sel ? va - vb : va + vb;
    if (sv < 0) begin
      m = 4'(-sv);
      return {1'b1, m};
    end
    m = 4'(sv);
    return {1'b0, m};
  endfunction

  initial begin
    logic [4:0] er;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.num1      = 3'b011;
    bus.num2      = 3'b011;
    bus.selection = 1'b0;

    @(posedge clk);
    #1;
    check("reset", 5'b00000, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;

    apply(3'b011, 3'b010, 1'b0);
    check("3+2", 5'b00101, 1'b0);
    apply(3'b001, 3'b011, 1'b1);
    check("1-3", 5'b10010, 1'b0);
    apply(3'b111, 3'b111, 1'b0);
    check("-3+-3", 5'b10110, 1'b0);
    apply(3'b011, 3'b111, 1'b1);
    check("3-(-3)", 5'b00110, 1'b0);
    apply(3'b100, 3'b000, 1'b0);
    check("-0+0", 5'b00000, 1'b1);
    apply(3'b110, 3'b110, 1'b1);
    check("-2-(-2)", 5'b00000, 1'b1);
    apply(3'b101, 3'b010, 1'b0);
    check("-1+2", 5'b00001, 1'b0);
    apply(3'b100, 3'b011, 1'b1);
    check("-0-3", 5'b10011, 1'b0);

    // Output must hold while idle between edges.
    #3;
    check("hold", 5'b10011, 1'b0);

    // Reset wins over live operands on the same edge.
    @(negedge clk);
    rst_n         = 1'b0;
    bus.num1      = 3'b011;
    bus.num2      = 3'b011;
    bus.selection = 1'b0;
    @(posedge clk);
    #1;
    check("reset_priority", 5'b00000, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 5'b00110, 1'b0);

    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      apply(v[6:4], v[3:1], v[0]);
      er = ref_result(v[6:4], v[3:1], v[0]);
      check($sformatf("sweep_%0d", i), er, er[3:0] == 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
